ft601_traffic_gen: RTL and testbench

- Synthesisable, parametrised, multi-channel packet traffic generator for the PL write side of ft601_mcfifo_if.
- Successor to the per-channel behavioural data sources: one block drives all NUM_CHANNELS write channels from a single round-robin scheduler.
- Adds selectable payload modes, self-describing headers, per-channel sequence numbers, channel masking and packet-space gating.
- Used in bring-up bitstreams and in the loopback bench.

---
 rtl/ft601_tg_pkg.sv | 43 ++++
 rtl/ft601_tg_lfsr.sv | 35 +++
 rtl/ft601_traffic_gen.sv | 236 +++++++++++++++++++++++
 tb/tb_ft601_traffic_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ft601_tg_pkg.sv
// rtl/ft601_tg_pkg.sv - shared types and constants for the FT601 traffic generator
// Contents: FSM state enum, payload mode enum, header field layout,
//           LFSR feedback mask, packet length clamp helper.
package ft601_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        WAIT_SPACE,
        STREAM,
        PUSH
    } tg_state_t;

    typedef enum logic {
        MODE_INC  = 1'b0,
        MODE_LFSR = 1'b1
    } tg_mode_t;

    // Header word layout: channel number, sequence number, clamped length.
    localparam int HDR_CH_LSB    = 0;
    localparam int HDR_CH_WIDTH  = 8;
    localparam int HDR_SEQ_LSB   = 8;
    localparam int HDR_SEQ_WIDTH = 8;
    localparam int HDR_LEN_LSB   = 16;

    // Right-shifting Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // Zero-length requests become a header-only packet; oversize requests
    // are cut to what fits in a maximum-size packet.
    function automatic logic [31:0] clamp_words(input logic [31:0] words,
                                                input logic [31:0] max_words);
        logic [31:0] result;
        result = words;
        if (words == 32'd0) begin
            result = 32'd1;
        end else if (words > max_words) begin
            result = max_words;
        end
        return result;
    endfunction

endpackage

// File: rtl/ft601_tg_lfsr.sv
// rtl/ft601_tg_lfsr.sv - 32-bit Galois LFSR with per-instance seed
// Ports: clk, reset_n (async active-low), advance_i (step one position),
//        state_o (current LFSR value, emitted before advancing).
module ft601_tg_lfsr
    import ft601_tg_pkg::*;
#(
    parameter logic [31:0] SEED = 32'd1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        advance_i,
    output logic [31:0] state_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (advance_i) begin
            state_d = {1'b0, state_q[31:1]} ^ (state_q[0] ? LFSR_POLY : 32'h0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/ft601_traffic_gen.sv
// rtl/ft601_traffic_gen.sv - multi-channel packet traffic generator for the FT601 write side
// Ports: clk, reset_n (async active-low), enable, mode (0 inc / 1 LFSR),
//        ch_mask, pkt_words, wr_full, has_wr_packet_space (per channel inputs);
//        wr_data, wr_be, wr_en, wr_push (per channel outputs), busy, pkt_count.
// Optional: FT601_TG_ERR_INJECT_EN adds err_inject; a rising edge flips bit 0
//           of the next accepted payload word.
module ft601_traffic_gen
    import ft601_tg_pkg::*;
#(
    parameter int NUM_CHANNELS    = 4,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_PACKET_SIZE = 1024,
    parameter int LEN_WIDTH       = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   enable,
    input  logic                                   mode,
`ifdef FT601_TG_ERR_INJECT_EN
    input  logic                                   err_inject,
`endif
    input  logic [NUM_CHANNELS-1:0]                ch_mask,
    input  logic [LEN_WIDTH-1:0]                   pkt_words,
    input  logic [NUM_CHANNELS-1:0]                wr_full,
    input  logic [NUM_CHANNELS-1:0]                has_wr_packet_space,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]     wr_data,
    output logic [NUM_CHANNELS*DATA_WIDTH/8-1:0]   wr_be,
    output logic [NUM_CHANNELS-1:0]                wr_en,
    output logic [NUM_CHANNELS-1:0]                wr_push,
    output logic                                   busy,
    output logic [31:0]                            pkt_count
);

    localparam int          BE_WIDTH  = DATA_WIDTH / 8;
    localparam int          CH_W      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [31:0] MAX_WORDS = 32'(MAX_PACKET_SIZE / BE_WIDTH);

    tg_state_t              state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [CH_W-1:0]        ptr_q, ptr_d;       // next channel to consider
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   idx_q, idx_d;       // word index within packet
    tg_mode_t               mode_q, mode_d;

    logic [7:0]             seq_q [NUM_CHANNELS];
    logic [DATA_WIDTH-1:0]  cnt_q [NUM_CHANNELS];
    logic [31:0]            pkt_count_q;

    logic [31:0]            lfsr_state [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] lfsr_adv;

    logic                   sel_found;
    logic [CH_W-1:0]        sel_ch;
    logic                   accept;
    logic                   last_word;
    logic                   payload_word;
    logic [31:0]            lfsr_cur;
    logic [DATA_WIDTH-1:0]  lfsr_word;
    logic [DATA_WIDTH-1:0]  header;
    logic [DATA_WIDTH-1:0]  word;

    function automatic logic [CH_W-1:0] wrap_ch(input int v);
        return CH_W'(v % NUM_CHANNELS);
    endfunction

    // Round-robin: first masked-in channel at or after the pointer.
    always_comb begin
        sel_found = 1'b0;
        sel_ch    = ptr_q;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!sel_found && ch_mask[wrap_ch(int'(ptr_q) + k)]) begin
                sel_found = 1'b1;
                sel_ch    = wrap_ch(int'(ptr_q) + k);
            end
        end
    end

    assign accept       = (state_q == STREAM) && !wr_full[ch_q];
    assign last_word    = (idx_q == len_q - LEN_WIDTH'(1));
    assign payload_word = (idx_q != '0);

`ifdef FT601_TG_ERR_INJECT_EN
    logic err_prev_q;
    logic err_arm_q;

    // A new rising edge wins over consumption so back-to-back requests
    // are not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_prev_q <= 1'b0;
            err_arm_q  <= 1'b0;
        end else begin
            err_prev_q <= err_inject;
            if (err_inject && !err_prev_q) begin
                err_arm_q <= 1'b1;
            end else if (accept && payload_word) begin
                err_arm_q <= 1'b0;
            end
        end
    end
`endif

    // Word presented on the active channel; the corruption is applied on the
    // output path only, so the generator state stays clean.
    always_comb begin
        lfsr_cur = lfsr_state[ch_q];
        header   = '0;
        header[HDR_CH_LSB  +: HDR_CH_WIDTH]  = 8'(int'(ch_q) + 1);
        header[HDR_SEQ_LSB +: HDR_SEQ_WIDTH] = seq_q[ch_q];
        header[HDR_LEN_LSB +: LEN_WIDTH]     = len_q;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            lfsr_word[b] = lfsr_cur[b % 32];
        end
        if (!payload_word) begin
            word = header;
        end else if (mode_q == MODE_LFSR) begin
            word = lfsr_word;
        end else begin
            word = cnt_q[ch_q];
        end
`ifdef FT601_TG_ERR_INJECT_EN
        if (err_arm_q && payload_word) begin
            word[0] = ~word[0];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        len_d   = len_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        wr_data = '0;
        wr_be   = '0;
        wr_en   = '0;
        wr_push = '0;
        case (state_q)
            IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    state_d = SELECT;
                end
            end
            SELECT: begin
                if (sel_found) begin
                    ch_d    = sel_ch;
                    ptr_d   = wrap_ch(int'(sel_ch) + 1);
                    len_d   = LEN_WIDTH'(clamp_words(32'(pkt_words), MAX_WORDS));
                    mode_d  = tg_mode_t'(mode);
                    idx_d   = '0;
                    state_d = WAIT_SPACE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_SPACE: begin
                if (has_wr_packet_space[ch_q]) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                wr_data[int'(ch_q)*DATA_WIDTH +: DATA_WIDTH] = word;
                if (accept) begin
                    wr_en[ch_q] = 1'b1;
                    wr_be[int'(ch_q)*BE_WIDTH +: BE_WIDTH] = {BE_WIDTH{1'b1}};
                    if (last_word) begin
                        state_d = PUSH;
                    end else begin
                        idx_d = idx_q + LEN_WIDTH'(1);
                    end
                end
            end
            PUSH: begin
                wr_push[ch_q] = 1'b1;
                state_d = (enable && (ch_mask != '0)) ? SELECT : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ch_q    <= '0;
            ptr_q   <= '0;
            len_q   <= LEN_WIDTH'(1);
            idx_q   <= '0;
            mode_q  <= MODE_INC;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_q <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                seq_q[i] <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            if (state_q == PUSH) begin
                seq_q[ch_q] <= seq_q[ch_q] + 8'd1;
                pkt_count_q <= pkt_count_q + 32'd1;
            end
            if (accept && payload_word && (mode_q == MODE_INC)) begin
                cnt_q[ch_q] <= cnt_q[ch_q] + DATA_WIDTH'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_lfsr
        assign lfsr_adv[i] = accept && payload_word && (mode_q == MODE_LFSR)
                             && (ch_q == CH_W'(i));
        ft601_tg_lfsr #(
            .SEED(32'(i + 1))
        ) u_lfsr (
            .clk      (clk),
            .reset_n  (reset_n),
            .advance_i(lfsr_adv[i]),
            .state_o  (lfsr_state[i])
        );
    end

    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ft601_traffic_gen.sv
// tb/tb_ft601_traffic_gen.sv - scoreboard bench for ft601_traffic_gen
module tb_ft601_traffic_gen;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          mode = 1'b0;
    logic [3:0]    ch_mask = 4'h0;
    logic [15:0]   pkt_words = 16'd4;
    logic [3:0]    wr_full = 4'h0;
    logic [3:0]    has_wr_packet_space = 4'hF;
    logic [127:0]  wr_data;
    logic [15:0]   wr_be;
    logic [3:0]    wr_en;
    logic [3:0]    wr_push;
    logic          busy;
    logic [31:0]   pkt_count;
`ifdef FT601_TG_ERR_INJECT_EN
    logic          err_inject = 1'b0;
`endif

    always #5 clk = ~clk;

    ft601_traffic_gen #(
        .NUM_CHANNELS(N),
        .DATA_WIDTH(DW),
        .MAX_PACKET_SIZE(1024),
        .LEN_WIDTH(16)
    ) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .mode               (mode),
`ifdef FT601_TG_ERR_INJECT_EN
        .err_inject         (err_inject),
`endif
        .ch_mask            (ch_mask),
        .pkt_words          (pkt_words),
        .wr_full            (wr_full),
        .has_wr_packet_space(has_wr_packet_space),
        .wr_data            (wr_data),
        .wr_be              (wr_be),
        .wr_en              (wr_en),
        .wr_push            (wr_push),
        .busy               (busy),
        .pkt_count          (pkt_count)
    );

    typedef struct {
        bit          is_push;
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_en = 4'h0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic exp_word(input int ch, input logic [31:0] d);
        exp_t e;
        e.is_push = 1'b0;
        e.ch      = ch;
        e.data    = d;
        sb.push_back(e);
    endtask

    task automatic exp_push(input int ch);
        exp_t e;
        e.is_push = 1'b1;
        e.ch      = ch;
        e.data    = 32'h0;
        sb.push_back(e);
    endtask

    // Header plus incrementing payload start, start+1, ... then the push.
    task automatic exp_inc(input int ch, input int seq, input int len, input int start);
        exp_word(ch, 32'((len << 16) | (seq << 8) | ch));
        for (int k = 0; k < len - 1; k++) begin
            exp_word(ch, 32'(start + k));
        end
        exp_push(ch);
    endtask

    // Monitor: every strobe the DUT presents is matched against the queue.
    always @(negedge clk) begin
        if (mon_en) begin
            check("strobe_onehot", 32'($onehot0(wr_en | wr_push)), 32'd1);
            for (int i = 0; i < N; i++) begin
                check("be_follows_en", 32'(wr_be[i*4 +: 4]), wr_en[i] ? 32'hF : 32'h0);
                if (wr_en[i]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_word", 32'(i + 1), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("word_kind", 32'(mon_e.is_push), 32'd0);
                        check("word_ch", 32'(i + 1), 32'(mon_e.ch));
                        check("word_data", wr_data[i*32 +: 32], mon_e.data);
                    end
                end
                if (wr_push[i]) begin
                    check("push_after_last", 32'(prev_en[i]), 32'd1);
                    if (sb.size() == 0) begin
                        check("unexpected_push", 32'(i + 1), 32'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("push_kind", 32'(mon_e.is_push), 32'd1);
                        check("push_ch", 32'(i + 1), 32'(mon_e.ch));
                    end
                end
            end
            prev_en = wr_en;
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (busy && t < budget);
        check(name, 32'(busy), 32'd0);
    endtask

    // Run exactly k packets: enable drops once the (k-1)th push is counted,
    // so the k-th packet is the last one started.
    task automatic run_packets(input string name, input int k);
        int start;
        int t;
        start  = int'(pkt_count);
        enable = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!busy && t < 20);
        if (!busy) check({name, "_start_timeout"}, 32'd0, 32'd1);
        t = 0;
        while (int'(pkt_count) != start + k - 1 && t < k * 300 + 50) begin
            @(negedge clk);
            t++;
        end
        enable = 1'b0;
        wait_idle({name, "_done_timeout"}, k * 300 + 50);
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        repeat (3) @(negedge clk);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_push", 32'(wr_push), 32'd0);
        check("rst_wr_be", 32'(wr_be), 32'd0);
        check("rst_wr_data", 32'(|wr_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_pkt_count", pkt_count, 32'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // Round robin over all four channels, incrementing payload.
        ch_mask = 4'b1111; pkt_words = 16'd4; mode = 1'b0;
        exp_word(1, 32'h0004_0001); exp_word(1, 32'd0); exp_word(1, 32'd1); exp_word(1, 32'd2); exp_push(1);
        exp_inc(2, 0, 4, 0);
        exp_inc(3, 0, 4, 0);
        exp_inc(4, 0, 4, 0);
        exp_inc(1, 1, 4, 3);
        run_packets("rr4", 5);
        check("rr4_pkt_count", pkt_count, 32'd5);

        // Mask 0101: pointer sits at channel 2, so channel 3 goes first.
        ch_mask = 4'b0101;
        exp_inc(3, 1, 4, 3);
        exp_inc(1, 2, 4, 6);
        run_packets("mask0101", 2);

        // Clearing the mask mid-packet still completes and pushes it.
        exp_inc(3, 2, 4, 6);
        enable = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wr_en[2] && t < 50);
        check("midclr_seen_ch3", 32'(wr_en[2]), 32'd1);
        ch_mask = 4'b0000;
        wait_idle("midclr_idle", 50);
        enable = 1'b0;
        check("midclr_drained", 32'(sb.size()), 32'd0);
        check("midclr_pkt_count", pkt_count, 32'd8);

        // Packet-space gating and wr_full backpressure on channel 1.
        ch_mask = 4'b0001; has_wr_packet_space = 4'b0000;
        exp_inc(1, 3, 4, 9);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("space_hold_busy", 32'(busy), 32'd1);
            check("space_hold_en", 32'(wr_en), 32'd0);
        end
        has_wr_packet_space = 4'b1111;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wr_en[0] && t < 20);
        check("bp_header_seen", 32'(wr_en[0]), 32'd1);
        @(posedge clk);
        #1 wr_full[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_held_en", 32'(wr_en), 32'd0);
            check("bp_held_data", wr_data[31:0], 32'd9);
        end
        @(posedge clk);
        #1 wr_full[0] = 1'b0;
        wait_idle("bp_idle", 50);
        check("bp_drained", 32'(sb.size()), 32'd0);
        check("bp_pkt_count", pkt_count, 32'd9);

        // Asynchronous reset in the middle of a packet.
        mon_en = 1'b0;
        @(negedge clk);
        ch_mask = 4'b0001; enable = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wr_en[0] && t < 20);
        check("rst2_streaming", 32'(wr_en[0]), 32'd1);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        check("rst2_wr_en", 32'(wr_en), 32'd0);
        check("rst2_wr_push", 32'(wr_push), 32'd0);
        check("rst2_wr_be", 32'(wr_be), 32'd0);
        check("rst2_wr_data", 32'(|wr_data), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        check("rst2_pkt_count", pkt_count, 32'd0);
        enable = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        prev_en = 4'h0;
        mon_en  = 1'b1;
        ch_mask = 4'b1111;
        exp_inc(1, 0, 4, 0);
        run_packets("after_rst", 1);
        check("after_rst_pkt_count", pkt_count, 32'd1);

        // LFSR payload on channel 2, seed 2.
        ch_mask = 4'b0010; mode = 1'b1; pkt_words = 16'd3;
        exp_word(2, 32'h0003_0002); exp_word(2, 32'h0000_0002); exp_word(2, 32'h0000_0001); exp_push(2);
        exp_word(2, 32'h0003_0102); exp_word(2, 32'h8020_0003); exp_word(2, 32'hC030_0002); exp_push(2);
        exp_word(2, 32'h0003_0202); exp_word(2, 32'h6018_0001); exp_word(2, 32'hB02C_0003); exp_push(2);
        run_packets("lfsr", 3);
        mode = 1'b0;

        // Length clamping at both ends.
        pkt_words = 16'd0;
        exp_word(2, 32'h0001_0302); exp_push(2);
        run_packets("len_zero", 1);
        pkt_words = 16'hFFFF;
        exp_inc(2, 4, 256, 0);
        run_packets("len_max", 1);

        // Sequence number wraps after 256 packets on one channel.
        ch_mask = 4'b1000; pkt_words = 16'd1;
        for (int s = 0; s < 257; s++) begin
            exp_word(4, 32'h0001_0004 | 32'((s % 256) << 8));
            exp_push(4);
        end
        run_packets("seq_wrap", 257);
        check("seq_wrap_pkt_count", pkt_count, 32'd263);

        ch_mask = 4'b0001; pkt_words = 16'd4;
`ifdef FT601_TG_ERR_INJECT_EN
        err_inject = 1'b1;
        @(negedge clk);
        err_inject = 1'b0;
        exp_word(1, 32'h0004_0101); exp_word(1, 32'd2); exp_word(1, 32'd4); exp_word(1, 32'd5); exp_push(1);
`else
        exp_word(1, 32'h0004_0101); exp_word(1, 32'd3); exp_word(1, 32'd4); exp_word(1, 32'd5); exp_push(1);
`endif
        run_packets("err_inj", 1);
        check("final_pkt_count", pkt_count, 32'd264);
        check("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
